uart_rx: RTL and testbench

- 8N1 UART receiver and the receive-side counterpart of the team's UART_TX: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Synchronises the asynchronous serial line, qualifies the start bit at mid-bit, and samples each data bit and the stop bit at its nominal centre.
- Presents each received byte with a one-cycle valid strobe; reports framing errors.
- Sits between the board RX pin and byte-level consumers such as the I2C bridge command parser.

---
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit start qualification,
// centre sampling of data and stop bits, one-cycle valid / framing-error strobes.
module uart_rx #(
  parameter int unsigned BAUD_COUNT = 104,
  parameter int unsigned HALF_COUNT = BAUD_COUNT / 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       RX_LINE,
  output logic [7:0] DATA,
  output logic       DATA_VALID,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int unsigned CNT_W  = 7;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned DATA_W = 8;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_COUNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_WAIT_HIGH,
    ST_IDLE,
    ST_START,
    ST_BITS,
    ST_STOP
  } state_t;

  state_t              state_q, state_d;
  logic                s1_q, s1_d;
  logic                s2_q, s2_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                data_valid_q, data_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                busy_q, busy_d;

  // State and datapath registers; synchronous active-low reset aborts any frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_WAIT_HIGH;
      s1_q         <= 1'b1;
      s2_q         <= 1'b1;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state and datapath logic; every decision looks only at the synchronised s2.
  always_comb begin
    state_d      = state_q;
    s1_d         = RX_LINE;
    s2_d         = s1_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      // A line held low (break, or low out of reset) must go high before a start counts.
      ST_WAIT_HIGH: begin
        if (s2_q) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (!s2_q) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      // Re-check the line at the middle of the start bit to reject glitches.
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (s2_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BITS;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_BITS: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d                = '0;
          shift_d[idx_q[2:0]]  = s2_q;
          idx_d                = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Returning to IDLE on the stop sample lets a back-to-back start be caught at once.
      ST_STOP: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d = '0;
          if (s2_q) begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            frame_err_d  = 1'b1;
            state_d      = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_WAIT_HIGH;
      end
    endcase

    busy_d = (state_d == ST_START) || (state_d == ST_BITS) || (state_d == ST_STOP);
  end

  assign DATA       = data_q;
  assign DATA_VALID = data_valid_q;
  assign FRAME_ERR  = frame_err_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 104 clk/bit: table of frames plus hand-written corner sequences.
module tb_uart_rx;

  localparam int unsigned BAUD = 104;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_line = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.BAUD_COUNT(BAUD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .RX_LINE    (rx_line),
    .DATA       (data),
    .DATA_VALID (data_valid),
    .FRAME_ERR  (frame_err),
    .BUSY       (busy)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge N (sampled #1 later or at the negedge) cyc == N.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Output monitor: pulse counts, last pulse cycles, BUSY edges, received bytes.
  int         dv_cnt = 0, fe_cnt = 0, dv_cyc = -1, fe_cyc = -1;
  int         busy_rise = -1, busy_fall = -1;
  bit         busy_prev = 1'b0, pulse_prev = 1'b0;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (data_valid === 1'b1 || frame_err === 1'b1) begin
      check("pulse_exclusive", int'(data_valid & frame_err), 0);
      check("pulse_single_cycle", int'(pulse_prev), 0);
    end
    pulse_prev = (data_valid === 1'b1) || (frame_err === 1'b1);
    if (data_valid === 1'b1) begin
      dv_cnt++;
      dv_cyc = cyc;
      rx_q.push_back(data);
    end
    if (frame_err === 1'b1) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (busy === 1'b1 && !busy_prev) busy_rise = cyc;
    if (busy !== 1'b1 && busy_prev)  busy_fall = cyc;
    busy_prev = (busy === 1'b1);
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame; start edge is the first posedge after the call (edge 1 = start+1).
  task automatic send_frame(input logic [7:0] b, input bit stop, input int low_hold,
                            input int gap, output int start);
    start   = cyc;
    rx_line = 1'b0;
    hold(BAUD);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      hold(BAUD);
    end
    rx_line = stop;
    hold(BAUD);
    if (low_hold > 0) begin
      rx_line = 1'b0;
      hold(low_hold);
    end
    rx_line = 1'b1;
    if (gap > 0) hold(gap);
  endtask

  typedef struct {
    logic [7:0] tx;
    bit         stop;
    int         low_hold;
    int         gap;
    int         exp_dv;
    int         exp_fe;
    logic [7:0] exp_data;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag, output int start);
    int dv0, fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(v.tx, v.stop, v.low_hold, v.gap, start);
    check({tag, "_dv_count"}, dv_cnt - dv0, v.exp_dv);
    check({tag, "_fe_count"}, fe_cnt - fe0, v.exp_fe);
    if (v.exp_dv != 0) check({tag, "_dv_cycle"}, dv_cyc - start, 991);
    if (v.exp_fe != 0) check({tag, "_fe_cycle"}, fe_cyc - start, 991);
    check({tag, "_busy_rise"}, busy_rise - start, 3);
    check({tag, "_busy_fall"}, busy_fall - start, 991);
    check({tag, "_data"}, int'(data), int'(v.exp_data));
  endtask

  vec_t       vecs[5];
  int         st, st2, dv0, fe0;
  int         dv_at[5];
  logic [7:0] sent[$];
  logic [7:0] b;

  initial begin
    // tx, stop, low_hold, gap, exp_dv, exp_fe, exp_data
    vecs[0] = '{8'hA5, 1'b1,   0, 20, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 200, 20, 0, 1, 8'hA5};
    vecs[2] = '{8'h81, 1'b1,   0, 20, 1, 0, 8'h81};
    vecs[3] = '{8'h00, 1'b1,   0,  0, 1, 0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1,   0, 20, 1, 0, 8'hFF};

    // Reset values, during and after reset.
    hold(3);
    check("rst_data", int'(data), 0);
    check("rst_dv", int'(data_valid), 0);
    check("rst_fe", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
    reset_n = 1'b1;
    hold(5);
    check("idle_busy", int'(busy), 0);
    check("idle_data", int'(data), 0);

    // Short low pulse: qualified away at the mid-start sample.
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    st  = cyc;
    rx_line = 1'b0;
    hold(20);
    rx_line = 1'b1;
    hold(60);
    check("glitch_busy_rise", busy_rise - st, 3);
    check("glitch_busy_fall", busy_fall - st, 55);
    check("glitch_dv_count", dv_cnt - dv0, 0);
    check("glitch_fe_count", fe_cnt - fe0, 0);
    check("glitch_data", int'(data), 0);

    // Table: good frame, framing error with held-low line, recovery, back-to-back pair.
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i), st);
      dv_at[i] = dv_cyc;
    end
    check("b2b_dv_spacing", dv_at[4] - dv_at[3], 1040);

    // Reset pulse at edge 570 (inside data bit 4) of frame 0x55.
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    fork
      send_frame(8'h55, 1'b1, 0, 0, st2);
      begin
        hold(569);
        reset_n = 1'b0;
        hold(1);
        reset_n = 1'b1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_data", int'(data), 0);
        check("midrst_dv", int'(data_valid), 0);
      end
    join
    check("midrst_dv_count", dv_cnt - dv0, 0);
    check("midrst_fe_count", fe_cnt - fe0, 0);
    // The falling edge of data bit 5 (edge 625) is then taken as a fresh start:
    // it samples bit6=1, bit7=0, stop=1, then idle-high ones -> 8'hFD at edge 1615.
    hold(600);
    check("resync_busy_rise", busy_rise - st2, 627);
    check("resync_dv_count", dv_cnt - dv0, 1);
    check("resync_dv_cycle", dv_cyc - st2, 1615);
    check("resync_data", int'(data), 'hFD);
    check("resync_fe_count", fe_cnt - fe0, 0);
    hold(20);
    run_vec('{8'h5A, 1'b1, 0, 20, 1, 0, 8'h5A}, "after_rst", st);

    // Back-to-back random bytes from a behavioural transmitter.
    rx_q.delete();
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      sent.push_back(b);
      send_frame(b, 1'b1, 0, 0, st);
    end
    hold(50);
    check("loop_dv_count", dv_cnt - dv0, 24);
    check("loop_fe_count", fe_cnt - fe0, 0);
    check("loop_rx_size", rx_q.size(), 24);
    for (int i = 0; i < 24; i++) begin
      if (i < rx_q.size())
        check($sformatf("loop_byte%0d", i), int'(rx_q[i]), int'(sent[i]));
      else
        check($sformatf("loop_byte%0d_missing", i), -1, int'(sent[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
